// File: rtl/vend_pkg.sv
// Shared types, default coin table and counter-width helper for the vend controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_VEND,
    ST_CHANGE,
    ST_PULSE,
    ST_GAP
  } vend_state_t;

  localparam int DEF_N_COIN = 3;
  localparam int DEF_AMT_W  = 9;
  localparam logic [DEF_N_COIN*DEF_AMT_W-1:0] DEF_COIN_VAL = {9'd25, 9'd10, 9'd5};

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/vend_multi_if.sv
// Signal bundle between coin-detect front end / solenoid drivers and the vend controller.
interface vend_multi_if
  import vend_pkg::*;
#(
  parameter int N_COIN = DEF_N_COIN,
  parameter int AMT_W  = DEF_AMT_W
);
  logic [N_COIN-1:0] detect;
  logic [AMT_W-1:0]  amount;
  logic              buy;
  logic              return_coins;
  logic              load;
  logic              ok;
  logic [N_COIN-1:0] ret;
  logic [AMT_W-1:0]  credit;
  logic [N_COIN-1:0] empty;
  logic              coin_rej;
  logic              short_chg;
  logic              busy;

  modport master (
    output detect, amount, buy, return_coins, load,
    input  ok, ret, credit, empty, coin_rej, short_chg, busy
  );

  modport slave (
    input  detect, amount, buy, return_coins, load,
    output ok, ret, credit, empty, coin_rej, short_chg, busy
  );
endinterface

// File: rtl/vend_coin_sel.sv
// Greedy change picker: one-hot of the highest-value stocked coin not exceeding acc.
module vend_coin_sel #(
  parameter int N_COIN = 3,
  parameter int AMT_W  = 9,
  parameter int INV_W  = 8,
  parameter logic [N_COIN*AMT_W-1:0] COIN_VAL = '0
) (
  input  logic [AMT_W-1:0]        acc,
  input  logic [N_COIN*INV_W-1:0] inv,
  output logic                    found,
  output logic [N_COIN-1:0]       sel_oh
);
  always_comb begin
    found  = 1'b0;
    sel_oh = '0;
    // Ascending scan so the last hit, i.e. the highest value, wins.
    for (int i = 0; i < N_COIN; i++) begin
      if (inv[i*INV_W +: INV_W] != '0 && COIN_VAL[i*AMT_W +: AMT_W] <= acc) begin
        found     = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vend_multi.sv
// Vend controller: accumulates coin credit, holds ok for a fixed vend time,
// then pays change greedily from per-denomination inventory via timed ret pulses.
module vend_multi
  import vend_pkg::*;
#(
  parameter int N_COIN    = DEF_N_COIN,
  parameter int AMT_W     = DEF_AMT_W,
  parameter logic [N_COIN*AMT_W-1:0] COIN_VAL = (N_COIN*AMT_W)'(DEF_COIN_VAL),
  parameter int INV_W     = 8,
  parameter int INV_INIT  = 4,
  parameter int DEB_CYC   = 24,
  parameter int VEND_CYC  = 150,
  parameter int PULSE_CYC = 1500,
  parameter int GAP_CYC   = 1500
) (
  input logic         clk,
  input logic         reset,
  vend_multi_if.slave bus
);
  localparam int MAX_A = (DEB_CYC > VEND_CYC) ? DEB_CYC : VEND_CYC;
  localparam int MAX_B = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW    = cnt_w((MAX_A > MAX_B) ? MAX_A : MAX_B);
  localparam logic [AMT_W:0]   ACC_MAX = {1'b0, {AMT_W{1'b1}}};
  localparam logic [INV_W-1:0] INV_MAX = '1;
  localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);

  vend_state_t             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AMT_W-1:0]        acc_q, acc_d, amt_q, amt_d;
  logic [N_COIN*INV_W-1:0] inv_q, inv_d;
  logic [N_COIN-1:0]       ret_q, ret_d, coin_q, coin_d;
  logic                    coin_rej_q, coin_rej_d, short_chg_q, short_chg_d;

  logic                    cnt_inc, buy_ok, settle_done, vend_done, pulse_done, gap_done;
  logic [N_COIN-1:0]       coin_oh, sel_oh, empty_v;
  logic [AMT_W-1:0]        coin_val, sel_val;
  logic [AMT_W:0]          coin_sum;
  logic                    sel_found;

  vend_coin_sel #(
    .N_COIN(N_COIN), .AMT_W(AMT_W), .INV_W(INV_W), .COIN_VAL(COIN_VAL)
  ) u_sel (
    .acc(acc_q), .inv(inv_q), .found(sel_found), .sel_oh(sel_oh)
  );

  always_comb begin
    coin_oh  = bus.detect & (~bus.detect + 1'b1);
    coin_val = '0;
    sel_val  = '0;
    for (int i = 0; i < N_COIN; i++) begin
      if (coin_oh[i]) coin_val = coin_val | COIN_VAL[i*AMT_W +: AMT_W];
      if (sel_oh[i])  sel_val  = sel_val  | COIN_VAL[i*AMT_W +: AMT_W];
    end
    coin_sum    = {1'b0, acc_q} + {1'b0, coin_val};
    buy_ok      = (bus.amount != '0) && (acc_q >= bus.amount);
    settle_done = (|(coin_q & ~bus.detect)) && (cnt_q == CW'(DEB_CYC - 1));
    vend_done   = (cnt_q == CW'(VEND_CYC - 1));
    pulse_done  = (cnt_q == CW'(PULSE_CYC - 1));
    gap_done    = (cnt_q == CW'(GAP_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      amt_q       <= '0;
      inv_q       <= {N_COIN{INV_RST}};
      ret_q       <= '0;
      coin_q      <= '0;
      coin_rej_q  <= 1'b0;
      short_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      inv_q       <= inv_d;
      ret_q       <= ret_d;
      coin_q      <= coin_d;
      coin_rej_q  <= coin_rej_d;
      short_chg_q <= short_chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load)              state_d = ST_IDLE;
        else if (|bus.detect)      state_d = ST_SETTLE;
        else if (bus.return_coins) state_d = ST_CHANGE;
        else if (bus.buy && buy_ok) state_d = ST_VEND;
      end
      ST_SETTLE: begin
        if (settle_done)                 state_d = ST_IDLE;
        else if (|(coin_q & ~bus.detect)) cnt_inc = 1'b1;
      end
      ST_VEND:   if (vend_done)  state_d = ST_CHANGE; else cnt_inc = 1'b1;
      ST_CHANGE: state_d = sel_found ? ST_PULSE : ST_IDLE;
      ST_PULSE:  if (pulse_done) state_d = ST_GAP;    else cnt_inc = 1'b1;
      ST_GAP:    if (gap_done)   state_d = ST_CHANGE; else cnt_inc = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
    // One counter serves every timed state; any state change restarts it.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_inc)       cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    acc_d       = acc_q;
    amt_d       = amt_q;
    inv_d       = inv_q;
    ret_d       = ret_q;
    coin_d      = coin_q;
    coin_rej_d  = 1'b0;
    short_chg_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          inv_d = {N_COIN{INV_RST}};
        end else if (|bus.detect) begin
          coin_d = coin_oh;
          if (coin_sum <= ACC_MAX) begin
            acc_d = coin_sum[AMT_W-1:0];
            for (int i = 0; i < N_COIN; i++)
              if (coin_oh[i] && inv_q[i*INV_W +: INV_W] != INV_MAX)
                inv_d[i*INV_W +: INV_W] = inv_q[i*INV_W +: INV_W] + 1'b1;
          end else begin
            coin_rej_d = 1'b1;
          end
        end else if (!bus.return_coins && bus.buy && buy_ok) begin
          amt_d = bus.amount;
        end
      end
      ST_VEND: if (vend_done) acc_d = acc_q - amt_q;
      ST_CHANGE: begin
        if (sel_found) begin
          ret_d = sel_oh;
          acc_d = acc_q - sel_val;
          for (int i = 0; i < N_COIN; i++)
            if (sel_oh[i]) inv_d[i*INV_W +: INV_W] = inv_q[i*INV_W +: INV_W] - 1'b1;
        end else if (acc_q != '0) begin
          short_chg_d = 1'b1;
          acc_d       = '0;
        end
      end
      ST_PULSE: if (pulse_done) ret_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    empty_v = '0;
    for (int i = 0; i < N_COIN; i++) empty_v[i] = (inv_q[i*INV_W +: INV_W] == '0);
    bus.ok        = (state_q == ST_VEND);
    bus.busy      = (state_q != ST_IDLE);
    bus.ret       = ret_q;
    bus.credit    = acc_q;
    bus.empty     = empty_v;
    bus.coin_rej  = coin_rej_q;
    bus.short_chg = short_chg_q;
  end
endmodule

// File: tb/tb_vend_multi.sv
// Bench for vend_multi: table vectors, cycle-exact corner sequences, random ops vs a model.
module tb_vend_multi;
  localparam int DEB = 4, VEND = 8, PULSE = 3, GAP = 2;
  localparam int OP_COIN = 0, OP_BUY = 1, OP_REF = 2, OP_LOAD = 3, OP_RST = 4;
  localparam logic [14:0] VAL_B = {5'd25, 5'd10, 5'd5};

  typedef struct {
    int op; int arg; int credit; int empty; int ok; int nret; longint code; int rej; int sh;
  } vec_t;

  logic clk;
  logic rst_a, rst_b, sel_b;
  logic [2:0] detect;
  logic [8:0] amount;
  logic buy, return_coins, load;

  vend_multi_if #(.N_COIN(3), .AMT_W(9)) bus_a ();
  vend_multi_if #(.N_COIN(3), .AMT_W(5)) bus_b ();

  assign bus_a.detect = detect;        assign bus_b.detect = detect;
  assign bus_a.amount = amount;        assign bus_b.amount = amount[4:0];
  assign bus_a.buy = buy;              assign bus_b.buy = buy;
  assign bus_a.return_coins = return_coins; assign bus_b.return_coins = return_coins;
  assign bus_a.load = load;            assign bus_b.load = load;

  vend_multi #(.DEB_CYC(DEB), .VEND_CYC(VEND), .PULSE_CYC(PULSE), .GAP_CYC(GAP))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  vend_multi #(.AMT_W(5), .COIN_VAL(VAL_B), .INV_INIT(0),
               .DEB_CYC(DEB), .VEND_CYC(VEND), .PULSE_CYC(PULSE), .GAP_CYC(GAP))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  logic       o_ok, o_busy, o_rej, o_short;
  logic [2:0] o_ret, o_empty;
  logic [8:0] o_credit;
  assign o_ok     = sel_b ? bus_b.ok        : bus_a.ok;
  assign o_busy   = sel_b ? bus_b.busy      : bus_a.busy;
  assign o_rej    = sel_b ? bus_b.coin_rej  : bus_a.coin_rej;
  assign o_short  = sel_b ? bus_b.short_chg : bus_a.short_chg;
  assign o_ret    = sel_b ? bus_b.ret       : bus_a.ret;
  assign o_empty  = sel_b ? bus_b.empty     : bus_a.empty;
  assign o_credit = sel_b ? {4'b0, bus_b.credit} : bus_a.credit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_bad;
  int obs_ok, obs_rej, obs_short, obs_rethi, obs_nret;
  longint obs_code;
  logic [2:0] prev_ret;
  vec_t tbl[$];

  // Reference model state
  int VAL [3] = '{5, 10, 25};
  int m_acc;
  int m_inv [3];
  int e_ok, e_nret, e_rej, e_sh;
  longint e_code;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (o_ok) obs_ok++;
    if (o_rej) obs_rej++;
    if (o_short) obs_short++;
    if (o_ret != 3'b0) obs_rethi++;
    if (o_ret != 3'b0 && prev_ret == 3'b0) begin
      int idx;
      idx = 0;
      for (int i = 2; i >= 0; i--) if (o_ret[i]) idx = i;
      obs_nret++;
      obs_code = obs_code * 4 + idx + 1;
    end
    prev_ret = o_ret;
  endtask

  task automatic run_op(input int op, input int arg);
    obs_ok = 0; obs_rej = 0; obs_short = 0; obs_rethi = 0; obs_nret = 0; obs_code = 0;
    case (op)
      OP_COIN: begin detect = arg[2:0]; step(); step(); detect = 3'b0; end
      OP_BUY:  begin amount = arg[8:0]; buy = 1'b1; step(); buy = 1'b0; end
      OP_REF:  begin return_coins = 1'b1; step(); return_coins = 1'b0; end
      OP_LOAD: begin load = 1'b1; step(); load = 1'b0; end
      default: begin
        if (sel_b) rst_b = 1'b1; else rst_a = 1'b1;
        step();
        if (sel_b) rst_b = 1'b0; else rst_a = 1'b0;
      end
    endcase
    for (int g = 0; g < 4000 && o_busy; g++) step();
    chk("idle_timeout", o_busy, 0);
  endtask

  task automatic add(input int op, input int arg, input int credit, input int empty,
                     input int ok, input int nret, input longint code, input int rej, input int sh);
    vec_t v;
    v.op = op; v.arg = arg; v.credit = credit; v.empty = empty; v.ok = ok;
    v.nret = nret; v.code = code; v.rej = rej; v.sh = sh;
    tbl.push_back(v);
  endtask

  task automatic apply_tbl(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      run_op(tbl[k].op, tbl[k].arg);
      chk($sformatf("%s%0d credit", tag, k), o_credit, tbl[k].credit);
      chk($sformatf("%s%0d empty", tag, k), o_empty, tbl[k].empty);
      chk($sformatf("%s%0d ok_cycles", tag, k), obs_ok, tbl[k].ok);
      chk($sformatf("%s%0d ret_count", tag, k), obs_nret, tbl[k].nret);
      chk($sformatf("%s%0d ret_order", tag, k), obs_code, tbl[k].code);
      chk($sformatf("%s%0d ret_high", tag, k), obs_rethi, PULSE * tbl[k].nret);
      chk($sformatf("%s%0d coin_rej", tag, k), obs_rej, tbl[k].rej);
      chk($sformatf("%s%0d short_chg", tag, k), obs_short, tbl[k].sh);
    end
    tbl.delete();
  endtask

  // Greedy payout from the highest denomination downward until nothing fits.
  task automatic model_change();
    for (int i = 2; i >= 0; i--)
      while (m_inv[i] > 0 && VAL[i] <= m_acc) begin
        m_acc -= VAL[i];
        m_inv[i]--;
        e_nret++;
        e_code = e_code * 4 + i + 1;
      end
    if (m_acc > 0) begin e_sh = 1; m_acc = 0; end
  endtask

  task automatic model_op(input int op, input int arg);
    e_ok = 0; e_nret = 0; e_code = 0; e_rej = 0; e_sh = 0;
    if (op == OP_COIN) begin
      int idx;
      idx = arg[0] ? 0 : (arg[1] ? 1 : 2);
      if (m_acc + VAL[idx] <= 511) begin
        m_acc += VAL[idx];
        if (m_inv[idx] < 255) m_inv[idx]++;
      end else e_rej = 1;
    end else if (op == OP_BUY) begin
      if (arg != 0 && m_acc >= arg) begin
        e_ok = VEND;
        m_acc -= arg;
        model_change();
      end
    end else if (op == OP_REF) begin
      model_change();
    end else if (op == OP_LOAD) begin
      for (int i = 0; i < 3; i++) m_inv[i] = 4;
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; prev_ret = 3'b0;
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    detect = 3'b0; amount = 9'd0; buy = 1'b0; return_coins = 1'b0; load = 1'b0;

    // op, arg, credit, empty, ok, nret, code, rej, short
    add(OP_RST,  0,  0, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 4, 25, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 2, 35, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 1, 40, 0, 0, 0, 0, 0, 0);
    add(OP_BUY, 30,  0, 0, VEND, 1, 2, 0, 0);
    add(OP_COIN, 4, 25, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 2, 35, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 1, 40, 0, 0, 0, 0, 0, 0);
    add(OP_REF,  0,  0, 0, 0, 3, 57, 0, 0);
    add(OP_BUY, 10,  0, 0, 0, 0, 0, 0, 0);
    add(OP_COIN, 1,  5, 0, 0, 0, 0, 0, 0);
    add(OP_BUY,  0,  5, 0, 0, 0, 0, 0, 0);
    add(OP_REF,  0,  0, 0, 0, 1, 1, 0, 0);
    add(OP_LOAD, 0,  0, 0, 0, 0, 0, 0, 0);
    apply_tbl("a");

    // Cycle-exact vend and change timing: 25 in, buy 20, one 5 back.
    run_op(OP_COIN, 4);
    amount = 9'd20; buy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      buy = 1'b0;
      chk($sformatf("tim%0d ok", k), o_ok, (k <= VEND) ? 1 : 0);
      chk($sformatf("tim%0d ret", k), o_ret, (k >= VEND + 2 && k <= VEND + 1 + PULSE) ? 1 : 0);
      chk($sformatf("tim%0d busy", k), o_busy, (k <= VEND + PULSE + GAP + 2) ? 1 : 0);
      if (k == VEND + 1) chk("tim change credit", o_credit, 5);
    end

    // Debounce: detect held long credits once; DEB low cycles needed to leave SETTLE.
    detect = 3'b001;
    for (int k = 0; k < 5; k++) begin step(); chk($sformatf("deb hold%0d busy", k), o_busy, 1); end
    detect = 3'b000;
    for (int k = 1; k <= DEB; k++) begin
      step();
      chk($sformatf("deb low%0d busy", k), o_busy, (k < DEB) ? 1 : 0);
    end
    chk("deb credit", o_credit, 5);

    // Reset while a return pulse is high.
    return_coins = 1'b1; step(); return_coins = 1'b0;
    for (int g = 0; g < 50 && o_ret == 3'b0; g++) step();
    chk("rst pulse seen", o_ret, 3'b001);
    step();
    rst_a = 1'b1; step(); rst_a = 1'b0;
    chk("rst ret", o_ret, 0);
    chk("rst credit", o_credit, 0);
    chk("rst busy", o_busy, 0);
    chk("rst ok", o_ok, 0);
    chk("rst empty", o_empty, 0);

    // Randomised operations against the model.
    run_op(OP_RST, 0);
    m_acc = 0;
    for (int i = 0; i < 3; i++) m_inv[i] = 4;
    for (int r = 0; r < 300; r++) begin
      int p, op, arg, hi, e_empty;
      p = $urandom_range(0, 9);
      arg = 0;
      if (p < 5)      begin op = OP_COIN; arg = $urandom_range(1, 7); end
      else if (p < 7) begin
        op = OP_BUY;
        hi = (m_acc + 15 > 511) ? 511 : m_acc + 15;
        arg = $urandom_range(0, hi);
      end
      else if (p < 9) op = OP_REF;
      else            op = OP_LOAD;
      model_op(op, arg);
      run_op(op, arg);
      e_empty = 0;
      for (int i = 0; i < 3; i++) if (m_inv[i] == 0) e_empty |= (1 << i);
      chk($sformatf("rnd%0d op%0d credit", r, op), o_credit, m_acc);
      chk($sformatf("rnd%0d op%0d empty", r, op), o_empty, e_empty);
      chk($sformatf("rnd%0d op%0d ok_cycles", r, op), obs_ok, e_ok);
      chk($sformatf("rnd%0d op%0d ret_order", r, op), obs_code, e_code);
      chk($sformatf("rnd%0d op%0d ret_high", r, op), obs_rethi, PULSE * e_nret);
      chk($sformatf("rnd%0d op%0d coin_rej", r, op), obs_rej, e_rej);
      chk($sformatf("rnd%0d op%0d short_chg", r, op), obs_short, e_sh);
    end

    // Narrow instance: 5-bit credit, empty inventory at reset.
    rst_a = 1'b1;
    sel_b = 1'b1;
    add(OP_RST,  0,  0, 7, 0, 0, 0, 0, 0);
    add(OP_COIN, 2, 10, 5, 0, 0, 0, 0, 0);
    add(OP_COIN, 1, 15, 4, 0, 0, 0, 0, 0);
    add(OP_REF,  0,  0, 7, 0, 2, 9, 0, 0);
    add(OP_RST,  0,  0, 7, 0, 0, 0, 0, 0);
    add(OP_COIN, 4, 25, 3, 0, 0, 0, 0, 0);
    add(OP_COIN, 1, 30, 2, 0, 0, 0, 0, 0);
    add(OP_BUY, 20,  0, 3, VEND, 1, 1, 0, 1);
    add(OP_COIN, 4, 25, 3, 0, 0, 0, 0, 0);
    add(OP_COIN, 2, 25, 3, 0, 0, 0, 1, 0);
    add(OP_RST,  0,  0, 7, 0, 0, 0, 0, 0);
    add(OP_COIN, 5,  5, 6, 0, 0, 0, 0, 0);
    apply_tbl("b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_multi.md
# vend_multi

Parametrised coin-operated vending controller, the next generation of the team's fixed three-coin vend block. Accepts N_COIN denominations, accumulates credit, grants a vend and pays change greedily from a per-denomination coin inventory that it tracks internally. All settle, vend and return-pulse delays are fixed parameters rather than randomised ranges. It sits between the coin-detect front end and the dispenser/return solenoid drivers.

## Interface
- N_COIN, 3: number of coin denominations, index 0..N_COIN-1.
- COIN_VAL, {25,10,5}: packed array of AMT_W-bit values; index 0 = 5, 1 = 10, 2 = 25; strictly ascending with index.
- AMT_W, 9: width of credit and price.
- INV_W, 8: width of each inventory counter.
- INV_INIT, 4: inventory value per denomination on reset or load.
- DEB_CYC, 24: detect-low cycles required after a coin before the next coin is sampled.
- VEND_CYC, 150: cycles ok is held.
- PULSE_CYC, 1500: cycles a ret bit is held high.
- GAP_CYC, 1500: low cycles after each return pulse.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- detect  in  N_COIN  coin-detect level, one bit per denomination.
- amount  in  AMT_W  price; sampled in IDLE on buy.
- buy  in  1  vend request level.
- return_coins  in  1  refund request level.
- load  in  1  reload all inventories to INV_INIT; honoured in IDLE only.
- ok  out  1  vend grant.
- ret  out  N_COIN  return-solenoid pulse, one bit per denomination.
- credit  out  AMT_W  current accumulator.
- empty  out  N_COIN  inventory[i]==0.
- coin_rej  out  1  one-cycle pulse: coin not credited because of overflow.
- short_chg  out  1  one-cycle pulse: change remainder forfeited because no coin could pay it.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, SETTLE, VEND, CHANGE, PULSE, GAP.
- IDLE priority (highest first): load, lowest-index detect bit, return_coins, buy. Other simultaneous detect bits are ignored.
- load in IDLE: every inventory = INV_INIT; stay in IDLE.
- Coin i in IDLE:
  - If acc+COIN_VAL[i] ≤ 2^AMT_W−1: acc += val and inventory[i] += 1, saturating at 2^INV_W−1.
  - Otherwise: acc is unchanged and coin_rej pulses.
  - Either way the next state is SETTLE with the counter cleared.
- SETTLE: counter increments only while detect[i]==0 and holds while it is 1. Return to IDLE on the cycle the count reaches DEB_CYC.
- return_coins: go to CHANGE.
- buy:
  - If amount != 0 and acc ≥ amount: go to VEND.
  - Otherwise stay in IDLE; buy is level-sampled again every cycle.
- VEND: ok = 1 for exactly VEND_CYC cycles. On exit, acc −= amount (amount captured when buy was accepted), then go to CHANGE.
- CHANGE picks the highest index i with inventory[i] > 0 and COIN_VAL[i] ≤ acc:
  - Coin found: set ret[i], acc −= val, inventory[i] −= 1, go to PULSE.
  - No coin and acc > 0: short_chg pulses, acc = 0, go to IDLE.
  - acc == 0: go to IDLE.
- PULSE: ret held for PULSE_CYC cycles, then all ret bits are cleared and the block enters GAP.
- GAP: GAP_CYC cycles, then back to CHANGE.
- Inputs other than reset are ignored outside IDLE/SETTLE. Only detect[i] matters in SETTLE.
- Arithmetic: acc is unsigned AMT_W bits and never wraps. Subtractions are guarded by the ≥ checks above.

## Timing
- Reset values: acc = 0, every inventory = INV_INIT, state = IDLE, ok = ret = coin_rej = short_chg = busy = 0, credit = 0, empty = 0 (when INV_INIT > 0).
- All outputs are registered or decoded from registered state. There is no combinational input→output path.
- buy accepted at edge t: ok high cycles t+1..t+VEND_CYC. CHANGE is at t+VEND_CYC+1 with credit already reduced.
- CHANGE at cycle c: ret high c+1..c+PULSE_CYC, low for GAP_CYC cycles, next CHANGE at c+PULSE_CYC+GAP_CYC+1.
- credit and empty update on the same edge as the state transition that changes them.
- Reset asserted in any state: on the next edge the block returns to the reset values, ret drops, and credit is lost.

## Structure
- Package vend_pkg holds:
  - state enum vend_state_t;
  - default COIN_VAL;
  - function cnt_w(max) returning $clog2(max+1), used for the shared counter width over DEB_CYC, VEND_CYC, PULSE_CYC and GAP_CYC.
- Sub-module vend_coin_sel: combinational greedy selector. Inputs acc, inventory vector and COIN_VAL; outputs found flag and one-hot index.
- A single shared counter is cleared on every state entry.

## Test plan
Bench uses DEB_CYC=4, VEND_CYC=8, PULSE_CYC=3, GAP_CYC=2, default values otherwise.
- Insert 25, 10, 5 (detect high 2 cycles each, then low) → credit 25, 35, 40; inventories 5,5,5.
- credit 40, amount 30, buy → ok high exactly 8 cycles; then ret[1] high 3 cycles; credit 0; inventory[1] = 4.
- credit 40, return_coins → ret[2] pulse (25 paid), ret[1] pulse (10 paid), ret[0] pulse (5 paid) in that order, each 3 high + 2 low; final credit 0.
- Inventory[1] = 0 and inventory[0] = 0 via reset with INV_INIT=0, credit 15 from one 10 + one 5, then refund → refund pays ret[1] (10) and ret[0] (5), because inserted coins refill the inventory. Then repeat with credit 30 after reset and coins consumed → short_chg pulses, credit 0.
- AMT_W=5: credit 25, insert 10 → coin_rej pulses, credit stays 25. Detect bits 0 and 2 high together in IDLE → only 5 credited.
- Reset asserted in the middle of PULSE → ret low and credit 0 on the next edge; busy 0; inventories = INV_INIT.
